iref_refresh: RTL and testbench

Autonomous sequencer that drives the current-reference macro's pd and charge pins in place of direct CPU bit-banging.
- Once enabled by the CPU, powers the reference up and waits a programmable settle time.
- Then pulses charge for a programmable width to load the sample-and-hold, and repeats the charge pulse at a programmable refresh period.
- Sits on the CPU peripheral bus; its pd/charge outputs go straight to the analog reference.

---
 rtl/iref_refresh_pkg.sv | 28 ++
 rtl/iref_refresh_cnt.sv | 37 +++
 rtl/iref_refresh.sv | 147 ++++++++++++++
 tb/tb_iref_refresh.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/iref_refresh_pkg.sv
//==============================================================================
// Module   : iref_refresh_pkg
// Brief    : Register map, CTRL bit positions and FSM state codes for iref_refresh
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

package iref_refresh_pkg;

    localparam int IREF_REFRESH_CTRL     = 0;
    localparam int IREF_REFRESH_SETTLE   = 1;
    localparam int IREF_REFRESH_CHARGE_W = 2;
    localparam int IREF_REFRESH_PERIOD   = 3;
    localparam int IREF_REFRESH_STATUS   = 4;

    localparam int CTRL_EN_BIT    = 0;
    localparam int CTRL_FORCE_BIT = 1;

    // State codes double as the STATUS[1:0] readback value
    localparam logic [1:0] ST_OFF    = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_CHARGE = 2'd2;
    localparam logic [1:0] ST_HOLD   = 2'd3;

endpackage

`default_nettype wire

// File: rtl/iref_refresh_cnt.sv
//==============================================================================
// Module   : iref_refresh_cnt
// Brief    : Loadable down-counter; done when the count is 1 or was loaded as 0
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

module iref_refresh_cnt #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic [CNT_W-1:0] value,
    output logic             done
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (load) begin
            r_cnt <= load_val;
        end else if (r_cnt > CNT_W'(1)) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    assign value = r_cnt;
    assign done  = (r_cnt <= CNT_W'(1));

endmodule

`default_nettype wire

// File: rtl/iref_refresh.sv
//==============================================================================
// Module   : iref_refresh
// Brief    : Current-reference power-up / periodic charge sequencer on CPU bus
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

module iref_refresh
    import iref_refresh_pkg::*;
#(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] wdata,
    input  logic              wstrb,
    output logic [DATA_W-1:0] rdata,
    output logic              ready,
    output logic              pd,
    output logic              charge,
    output logic              busy
);

    logic              r_en;
    logic [CNT_W-1:0]  r_settle, r_charge_w, r_period;
    logic [7:0]        r_refresh_cnt;
    logic [1:0]        r_state;
    logic              r_ready, r_pd, r_charge, r_busy;
    logic [DATA_W-1:0] r_rdata;

    logic              w_wr, w_ctrl_wr, w_en_nxt, w_force;
    logic [1:0]        w_state_nxt;
    logic              w_load, w_cnt_done;
    logic [CNT_W-1:0]  w_load_val, w_cnt_value;
    logic [DATA_W-1:0] w_rdata;
    logic              w_unused;

    assign w_wr      = valid && wstrb;
    assign w_ctrl_wr = w_wr && (address == ADDR_W'(IREF_REFRESH_CTRL));
    // The FSM reacts to a CTRL write at the same edge that stores it
    assign w_en_nxt  = w_ctrl_wr ? wdata[CTRL_EN_BIT] : r_en;
    assign w_force   = w_ctrl_wr && wdata[CTRL_FORCE_BIT];

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_OFF:    if (w_en_nxt) w_state_nxt = ST_SETTLE;
            ST_SETTLE: if (!w_en_nxt) w_state_nxt = ST_OFF;
                       else if (w_cnt_done) w_state_nxt = ST_CHARGE;
            ST_CHARGE: if (!w_en_nxt) w_state_nxt = ST_OFF;
                       else if (w_cnt_done) w_state_nxt = ST_HOLD;
            ST_HOLD:   if (!w_en_nxt) w_state_nxt = ST_OFF;
                       else if (w_cnt_done || w_force) w_state_nxt = ST_CHARGE;
            default:   w_state_nxt = ST_OFF;
        endcase
    end

    // Every transition changes state, so a state change marks a counter load
    assign w_load = (w_state_nxt != r_state);

    always_comb begin
        case (w_state_nxt)
            ST_SETTLE: w_load_val = r_settle;
            ST_HOLD:   w_load_val = r_period;
            default:   w_load_val = r_charge_w;
        endcase
    end

    iref_refresh_cnt #(.CNT_W(CNT_W)) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (w_load),
        .load_val (w_load_val),
        .value    (w_cnt_value),
        .done     (w_cnt_done)
    );

    always_comb begin
        w_rdata = '0;
        case (int'(address))
            IREF_REFRESH_CTRL:     w_rdata[CTRL_EN_BIT] = r_en;
            IREF_REFRESH_SETTLE:   w_rdata[CNT_W-1:0]   = r_settle;
            IREF_REFRESH_CHARGE_W: w_rdata[CNT_W-1:0]   = r_charge_w;
            IREF_REFRESH_PERIOD:   w_rdata[CNT_W-1:0]   = r_period;
            IREF_REFRESH_STATUS: begin
                w_rdata[1:0]  = r_state;
                w_rdata[15:8] = r_refresh_cnt;
            end
            default:               w_rdata = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ready    <= 1'b0;
            r_rdata    <= '0;
            r_en       <= 1'b0;
            r_settle   <= '0;
            r_charge_w <= '0;
            r_period   <= '0;
        end else begin
            r_ready <= valid;
            r_rdata <= (valid && !wstrb) ? w_rdata : '0;
            if (w_wr) begin
                case (int'(address))
                    IREF_REFRESH_CTRL:     r_en       <= wdata[CTRL_EN_BIT];
                    IREF_REFRESH_SETTLE:   r_settle   <= wdata[CNT_W-1:0];
                    IREF_REFRESH_CHARGE_W: r_charge_w <= wdata[CNT_W-1:0];
                    IREF_REFRESH_PERIOD:   r_period   <= wdata[CNT_W-1:0];
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_OFF;
            r_refresh_cnt <= 8'd0;
            r_pd          <= 1'b1;
            r_charge      <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_pd     <= (w_state_nxt == ST_OFF);
            r_charge <= (w_state_nxt == ST_CHARGE);
            r_busy   <= (w_state_nxt != ST_OFF);
            if (r_state == ST_CHARGE && w_state_nxt == ST_HOLD)
                r_refresh_cnt <= r_refresh_cnt + 8'd1;
        end
    end

    assign rdata    = r_rdata;
    assign ready    = r_ready;
    assign pd       = r_pd;
    assign charge   = r_charge;
    assign busy     = r_busy;
    assign w_unused = ^{wdata[DATA_W-1:CNT_W], w_cnt_value};

endmodule

`default_nettype wire

// File: tb/tb_iref_refresh.sv
//==============================================================================
// Module   : tb_iref_refresh
// Brief    : Directed self-checking bench for the iref_refresh sequencer
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_iref_refresh;

    localparam int ADDR_W = 3;
    localparam int DATA_W = 32;
    localparam int CNT_W  = 16;

    logic              clk = 1'b0;
    logic              rst, valid, wstrb;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              ready, pd, charge, busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    iref_refresh #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk     (clk),
        .rst     (rst),
        .valid   (valid),
        .address (address),
        .wdata   (wdata),
        .wstrb   (wstrb),
        .rdata   (rdata),
        .ready   (ready),
        .pd      (pd),
        .charge  (charge),
        .busy    (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        valid = 1'b1; wstrb = 1'b1; address = a; wdata = d;
        tick();
        chk("wr_ready", ready, 1);
        valid = 1'b0; wstrb = 1'b0;
    endtask

    task automatic read_chk(input string tag, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] exp);
        valid = 1'b1; wstrb = 1'b0; address = a; wdata = '0;
        tick();
        chk({tag, "_ready"}, ready, 1);
        chk(tag, rdata, exp);
        valid = 1'b0;
    endtask

    task automatic chk_outs(input string tag, input logic e_pd, input logic e_chg, input logic e_busy);
        chk({tag, "_pd"}, pd, e_pd);
        chk({tag, "_charge"}, charge, e_chg);
        chk({tag, "_busy"}, busy, e_busy);
    endtask

    initial begin
        rst = 1'b1; valid = 1'b0; wstrb = 1'b0; address = '0; wdata = '0;
        tick(); tick();
        rst = 1'b0;

        // Reset state and bus handshake timing
        chk_outs("rst", 1'b1, 1'b0, 1'b0);
        chk("rst_ready", ready, 0);
        chk("rst_rdata", rdata, 0);
        read_chk("t1_status", 3'd4, 32'h0);
        tick();
        chk("t1_ready_drop", ready, 0);

        // Settle 4, charge 2, period 5: pulses at ticks 4-5, 11-12, 18-19
        bus_write(3'd1, 32'd4);
        bus_write(3'd2, 32'd2);
        bus_write(3'd3, 32'd5);
        bus_write(3'd0, 32'd1);
        chk_outs("t2_start", 1'b0, 1'b0, 1'b1);
        for (int i = 1; i <= 20; i++) begin
            tick();
            chk($sformatf("t2_charge_%0d", i), charge,
                (i == 4 || i == 5 || i == 11 || i == 12 || i == 18 || i == 19) ? 1 : 0);
        end
        read_chk("t2_status", 3'd4, 32'h0000_0303);

        // PERIOD 5 -> 8 mid-HOLD: current HOLD ends on schedule, next one is 8 long
        bus_write(3'd3, 32'd8);
        for (int i = 1; i <= 13; i++) begin
            tick();
            chk($sformatf("t6_charge_%0d", i), charge,
                (i == 3 || i == 4 || i == 13) ? 1 : 0);
        end
        tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_outs("t6_rst", 1'b1, 1'b0, 1'b0);
        chk("t6_rst_ready", ready, 0);
        read_chk("t6_settle", 3'd1, 32'h0);
        read_chk("t6_ctrl", 3'd0, 32'h0);
        read_chk("t6_status", 3'd4, 32'h0);

        // EN cleared on the first cycle of a 10-cycle charge pulse
        bus_write(3'd1, 32'd2);
        bus_write(3'd2, 32'd10);
        bus_write(3'd3, 32'd3);
        bus_write(3'd0, 32'd1);
        tick();
        chk("t4_charge_pre", charge, 0);
        tick();
        chk("t4_charge_on", charge, 1);
        bus_write(3'd0, 32'd0);
        chk_outs("t4_off", 1'b1, 1'b0, 1'b0);
        read_chk("t4_status", 3'd4, 32'h0);

        // FORCE ignored in SETTLE, honoured in HOLD; EN=0 with FORCE=1 turns off
        bus_write(3'd1, 32'd3);
        bus_write(3'd2, 32'd1);
        bus_write(3'd3, 32'd1000);
        bus_write(3'd0, 32'd1);
        bus_write(3'd0, 32'd3);
        chk("t5_settle_a", charge, 0);
        tick();
        chk("t5_settle_b", charge, 0);
        tick();
        chk("t5_charge", charge, 1);
        tick();
        chk("t5_hold_1", charge, 0);
        tick();
        tick();
        chk("t5_hold_3", charge, 0);
        bus_write(3'd0, 32'd3);
        chk("t5_forced", charge, 1);
        tick();
        chk("t5_forced_end", charge, 0);
        read_chk("t5_status", 3'd4, 32'h0000_0203);
        bus_write(3'd0, 32'd2);
        chk_outs("t5_en_wins", 1'b1, 1'b0, 1'b0);
        read_chk("t5_ctrl", 3'd0, 32'h0);
        read_chk("t5_unmapped", 3'd6, 32'h0);

        // All counts zero: 1-cycle states, refresh_cnt wraps after 256 pulses
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus_write(3'd0, 32'd1);
        chk("t3_charge_0", charge, 0);
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk($sformatf("t3_charge_%0d", i), charge, (i % 2 == 1) ? 1 : 0);
        end
        repeat (507) tick();
        read_chk("t3_cnt255", 3'd4, 32'h0000_FF02);
        read_chk("t3_wrap", 3'd4, 32'h0000_0003);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
